rf_text_screen_ram_ctrl: RTL and testbench
==========================================

# rf_text_screen_ram_ctrl

Port-A sequencer for the text screen RAM (true dual-port block RAM, byte write enables, port A read latency 2). It shares port A between the CPU bus slave and a hardware block engine that fills or copies runs of text cells (screen clear, scroll). Port B stays with the video fetch logic and is not touched. The block sits between the bus decode and the RAM instance in the text controller top level.

## Interface
Parameters:
- WID, 64: cell/data width; must be a multiple of 8.
- TEXT_CELL_COUNT, 16384: cells in RAM; power of two.
- AWID, $clog2(TEXT_CELL_COUNT): cell address width.

Ports:
- clk_i  in  1  single clock for all logic and RAM port A.
- rstn_i  in  1  asynchronous, active-low reset.
- cpu_cs_i  in  1  CPU request; held until cpu_ack_o.
- cpu_we_i  in  1  1 = write.
- cpu_sel_i  in  WID/8  byte selects.
- cpu_adr_i  in  AWID  cell address.
- cpu_dat_i  in  WID  write data.
- cpu_dat_o  out  WID  read data; valid with cpu_ack_o.
- cpu_ack_o  out  1  one-cycle acknowledge.
- cmd_valid_i  in  1  engine command offered.
- cmd_ready_o  out  1  engine idle, command accepted on valid&ready.
- cmd_op_i  in  1  0 = FILL, 1 = COPY.
- cmd_src_i  in  AWID  COPY source start.
- cmd_dst_i  in  AWID  destination start.
- cmd_len_i  in  AWID+1  cell count, 0..TEXT_CELL_COUNT.
- cmd_fill_i  in  WID  FILL pattern.
- busy_o  out  1  engine command in progress.
- done_o  out  1  one-cycle pulse at command completion.
- ram_cs_o, ram_we_o  out  1  port A enable / write.
- ram_sel_o  out  WID/8  port A byte enables (all ones for engine writes).
- ram_adr_o  out  AWID  port A address.
- ram_dat_o  out  WID  port A write data.
- ram_dat_i  in  WID  port A read data.

## Operation
- All outputs are registered. Reset value of every output is 0, except cmd_ready_o, which is 1. Reset is asynchronous and aborts any command with no done_o.
- FSM states: IDLE, CPU_RD (wait count 0..2), CPU_GAP, FILL, CP_RD, CP_W1, CP_W2, CP_WR, DONE.
- Arbitration is decided in IDLE and at every engine cell boundary. A pending cpu_cs_i always wins over the engine. The engine resumes at the same cell after the CPU access completes.
- CPU write: ram_* is driven for one cycle with cpu_sel_i, and cpu_ack_o is asserted in the same cycle.
- CPU read: a one-cycle ram read, then wait for the data. cpu_dat_o captures ram_dat_i, and cpu_ack_o is asserted with it.
- After any cpu_ack_o, the FSM passes through CPU_GAP for one cycle and ignores cpu_cs_i there, so a held cs is not serviced twice.
- Command accept: registers src, dst, len and pattern, drops cmd_ready_o, and raises busy_o.
  - len = 0: go straight to DONE with no RAM access.
- FILL: one write per cycle to dst, then dst+1, and so on.
- COPY, per cell:
  - CP_RD reads src.
  - CP_W1 and CP_W2 wait.
  - ram_dat_i is captured at the end of CP_W2.
  - CP_WR writes the captured data to dst.
- Addresses increment modulo TEXT_CELL_COUNT, so the run wraps from TEXT_CELL_COUNT-1 to 0.
- The cell counter counts down from len. The engine stops when the counter reaches 0.
- Copies always run in ascending order.
  - Overlap with dst < src (scroll up) is exact.
  - Overlap with dst > src propagates already-copied cells; this is defined behaviour, not an error.
- DONE: done_o is high for 1 cycle, then busy_o drops and cmd_ready_o rises in the next cycle.

## Timing
- CPU write latency: cpu_cs_i is sampled in IDLE at cycle 0; ram write and cpu_ack_o occur in cycle 1.
- CPU read latency: cs sampled at cycle 0, ram read in cycle 1, data valid in cycle 3, cpu_ack_o and cpu_dat_o in cycle 4.
- FILL throughput: 1 cell/cycle. A FILL of N cells with no CPU traffic shows done_o at cycle N+1 after the accept cycle.
- COPY throughput: 4 cycles/cell. A COPY of N cells shows done_o at cycle 4N+1.
- CPU preemption costs one CPU access plus the CPU_GAP cycle.
- cmd_valid_i while busy: ignored; the source holds it until ready.
- cmd_valid_i and cpu_cs_i in the same IDLE cycle: the CPU is serviced first, and the command is accepted in the next IDLE cycle.

## Structure
- Shared package rf_text_screen_pkg holds:
  - the op enum (OP_FILL, OP_COPY);
  - the FSM state enum;
  - the RAM port-A read latency constant RAM_RDLAT_A = 2, which sizes the wait counters.
- No sub-module. The RAM is instantiated beside this block at the parent level.

## Test plan
- Reset mid-COPY: assert rstn_i low during CP_W1. All outputs go to 0 immediately, cmd_ready_o = 1, and no done_o is produced.
- CPU write then read: write adr 0x0010 with 0x1122334455667788 and sel 0x0F, then read back. The low 4 bytes match and the high bytes keep their prior value. The read ack arrives 4 cycles after cs.
- FILL dst 0x3FFE, len 4, pattern 0x0720: cells 0x3FFE, 0x3FFF, 0x0000 and 0x0001 are written, and done_o appears 5 cycles after accept.
- COPY src 80, dst 0, len 160 (scroll up one row): cells 0..159 equal the old cells 80..239, and done_o appears at cycle 641.
- CPU read issued continuously during FILL len 100: each CPU access completes with correct latency, and the fill finishes with all 100 cells correct and no cell skipped or duplicated.
- len 0 and len 16384 commands: len 0 gives done_o 1 cycle after accept with no ram_cs_o; len 16384 FILL writes every cell exactly once.

Source files
------------

// File: rtl/rf_text_screen_pkg.sv
// Shared types and constants for the text screen RAM port-A sequencer.
package rf_text_screen_pkg;

    localparam int RAM_RDLAT_A = 2;
    localparam int WAIT_W      = $clog2(RAM_RDLAT_A + 1);

    typedef enum logic {
        OP_FILL = 1'b0,
        OP_COPY = 1'b1
    } op_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CPU_RD,
        ST_CPU_GAP,
        ST_FILL,
        ST_CP_RD,
        ST_CP_W1,
        ST_CP_W2,
        ST_CP_WR,
        ST_DONE
    } state_e;

endpackage

// File: rtl/rf_text_screen_ram_ctrl.sv
// Port-A sequencer sharing the text RAM between the CPU bus and the fill/copy engine.
// Every output is registered and reflects the state being entered on that edge.
//   state      | meaning
//   IDLE       | no access; CPU has priority over a new command
//   CPU_RD     | CPU read in flight, wait_q counts RAM latency
//   CPU_GAP    | cpu_ack_o visible; held cs ignored, engine resumes
//   FILL       | engine write of one fill cell
//   CP_RD      | engine read of copy source cell
//   CP_W1/W2   | waiting for read data, captured at end of CP_W2
//   CP_WR      | engine write of copied cell
//   DONE       | done_o pulse, then back to IDLE
module rf_text_screen_ram_ctrl
    import rf_text_screen_pkg::*;
#(
    parameter int WID             = 64,
    parameter int TEXT_CELL_COUNT = 16384,
    parameter int AWID            = $clog2(TEXT_CELL_COUNT)
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              cpu_cs_i,
    input  logic              cpu_we_i,
    input  logic [WID/8-1:0]  cpu_sel_i,
    input  logic [AWID-1:0]   cpu_adr_i,
    input  logic [WID-1:0]    cpu_dat_i,
    output logic [WID-1:0]    cpu_dat_o,
    output logic              cpu_ack_o,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_op_i,
    input  logic [AWID-1:0]   cmd_src_i,
    input  logic [AWID-1:0]   cmd_dst_i,
    input  logic [AWID:0]     cmd_len_i,
    input  logic [WID-1:0]    cmd_fill_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              ram_cs_o,
    output logic              ram_we_o,
    output logic [WID/8-1:0]  ram_sel_o,
    output logic [AWID-1:0]   ram_adr_o,
    output logic [WID-1:0]    ram_dat_o,
    input  logic [WID-1:0]    ram_dat_i
);

    localparam int SELW = WID / 8;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RAM_RDLAT_A);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    op_e               op_q, op_d;
    logic [AWID-1:0]   src_q, src_d, dst_q, dst_d;
    logic [AWID:0]     cnt_q, cnt_d;
    logic [WID-1:0]    fill_q, fill_d;
    logic              cpu_go, eng_go;

    logic [WID-1:0]    cpu_dat_d;
    logic              cpu_ack_d, ready_d, busy_d, done_d, ram_cs_d, ram_we_d;
    logic [SELW-1:0]   ram_sel_d;
    logic [AWID-1:0]   ram_adr_d;
    logic [WID-1:0]    ram_dat_d;

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        op_d      = op_q;
        src_d     = src_q;
        dst_d     = dst_q;
        cnt_d     = cnt_q;
        fill_d    = fill_q;
        cpu_dat_d = cpu_dat_o;
        cpu_ack_d = 1'b0;
        ready_d   = cmd_ready_o;
        busy_d    = busy_o;
        done_d    = 1'b0;
        ram_cs_d  = 1'b0;
        ram_we_d  = 1'b0;
        ram_sel_d = ram_sel_o;
        ram_adr_d = ram_adr_o;
        ram_dat_d = ram_dat_o;
        cpu_go    = 1'b0;
        eng_go    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cpu_cs_i) begin
                    cpu_go = 1'b1;
                end else if (cmd_valid_i) begin
                    op_d    = op_e'(cmd_op_i);
                    src_d   = cmd_src_i;
                    dst_d   = cmd_dst_i;
                    cnt_d   = cmd_len_i;
                    fill_d  = cmd_fill_i;
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                    if (cmd_len_i == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        eng_go = 1'b1;
                    end
                end
            end
            ST_CPU_RD: begin
                if (wait_q == WAIT_LAST) begin
                    cpu_dat_d = ram_dat_i;
                    cpu_ack_d = 1'b1;
                    state_d   = ST_CPU_GAP;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_CPU_GAP: begin
                if (busy_o) eng_go = 1'b1;
                else        state_d = ST_IDLE;
            end
            ST_FILL, ST_CP_WR: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else if (cpu_cs_i) begin
                    cpu_go = 1'b1;
                end else begin
                    eng_go = 1'b1;
                end
            end
            ST_CP_RD: state_d = ST_CP_W1;
            ST_CP_W1: state_d = ST_CP_W2;
            ST_CP_W2: begin
                ram_cs_d  = 1'b1;
                ram_we_d  = 1'b1;
                ram_sel_d = '1;
                ram_adr_d = dst_q;
                ram_dat_d = ram_dat_i;
                dst_d     = dst_q + 1'b1;
                cnt_d     = cnt_q - 1'b1;
                state_d   = ST_CP_WR;
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (cpu_go) begin
            ram_cs_d  = 1'b1;
            ram_sel_d = cpu_sel_i;
            ram_adr_d = cpu_adr_i;
            ram_dat_d = cpu_dat_i;
            if (cpu_we_i) begin
                ram_we_d  = 1'b1;
                cpu_ack_d = 1'b1;
                state_d   = ST_CPU_GAP;
            end else begin
                wait_d  = '0;
                state_d = ST_CPU_RD;
            end
        end

        // Uses the *_d values so a command can issue its first cell on the accept edge.
        if (eng_go) begin
            ram_cs_d = 1'b1;
            if (op_d == OP_FILL) begin
                ram_we_d  = 1'b1;
                ram_sel_d = '1;
                ram_adr_d = dst_d;
                ram_dat_d = fill_d;
                dst_d     = dst_d + 1'b1;
                cnt_d     = cnt_d - 1'b1;
                state_d   = ST_FILL;
            end else begin
                ram_adr_d = src_d;
                src_d     = src_d + 1'b1;
                state_d   = ST_CP_RD;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= ST_IDLE;
            wait_q      <= '0;
            op_q        <= OP_FILL;
            src_q       <= '0;
            dst_q       <= '0;
            cnt_q       <= '0;
            fill_q      <= '0;
            cpu_dat_o   <= '0;
            cpu_ack_o   <= 1'b0;
            cmd_ready_o <= 1'b1;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            ram_cs_o    <= 1'b0;
            ram_we_o    <= 1'b0;
            ram_sel_o   <= '0;
            ram_adr_o   <= '0;
            ram_dat_o   <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            op_q        <= op_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            cnt_q       <= cnt_d;
            fill_q      <= fill_d;
            cpu_dat_o   <= cpu_dat_d;
            cpu_ack_o   <= cpu_ack_d;
            cmd_ready_o <= ready_d;
            busy_o      <= busy_d;
            done_o      <= done_d;
            ram_cs_o    <= ram_cs_d;
            ram_we_o    <= ram_we_d;
            ram_sel_o   <= ram_sel_d;
            ram_adr_o   <= ram_adr_d;
            ram_dat_o   <= ram_dat_d;
        end
    end

endmodule

// File: tb/tb_rf_text_screen_ram_ctrl.sv
// Bench for rf_text_screen_ram_ctrl: latency-2 RAM model plus an array-based reference of screen contents.
module tb_rf_text_screen_ram_ctrl;

    localparam int WID  = 64;
    localparam int N    = 16384;
    localparam int AW   = 14;
    localparam int SELW = 8;

    logic            clk = 1'b0;
    logic            rstn;
    logic            cpu_cs, cpu_we;
    logic [SELW-1:0] cpu_sel;
    logic [AW-1:0]   cpu_adr;
    logic [WID-1:0]  cpu_dat, cpu_dat_o;
    logic            cpu_ack_o;
    logic            cmd_valid, cmd_ready_o, cmd_op;
    logic [AW-1:0]   cmd_src, cmd_dst;
    logic [AW:0]     cmd_len;
    logic [WID-1:0]  cmd_fill;
    logic            busy_o, done_o;
    logic            ram_cs_o, ram_we_o;
    logic [SELW-1:0] ram_sel_o;
    logic [AW-1:0]   ram_adr_o;
    logic [WID-1:0]  ram_dat_o, ram_dat_i;

    always #5 clk = ~clk;

    rf_text_screen_ram_ctrl #(.WID(WID), .TEXT_CELL_COUNT(N)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .cpu_cs_i(cpu_cs), .cpu_we_i(cpu_we), .cpu_sel_i(cpu_sel), .cpu_adr_i(cpu_adr),
        .cpu_dat_i(cpu_dat), .cpu_dat_o(cpu_dat_o), .cpu_ack_o(cpu_ack_o),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op),
        .cmd_src_i(cmd_src), .cmd_dst_i(cmd_dst), .cmd_len_i(cmd_len), .cmd_fill_i(cmd_fill),
        .busy_o(busy_o), .done_o(done_o),
        .ram_cs_o(ram_cs_o), .ram_we_o(ram_we_o), .ram_sel_o(ram_sel_o),
        .ram_adr_o(ram_adr_o), .ram_dat_o(ram_dat_o), .ram_dat_i(ram_dat_i)
    );

    logic [WID-1:0] mem [N];
    logic [WID-1:0] ref_mem [N];
    logic [WID-1:0] q1, q2;
    logic [31:0]    salt;
    logic           load_req;
    int             cs_total, wr_total, ack_total, done_total;
    int             total = 0, bad = 0;

    function automatic logic [63:0] seed_fn(input int a);
        return {32'(a) * 32'h9E3779B1, salt ^ 32'(a)};
    endfunction

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < N; i++) mem[i] <= seed_fn(i);
        end else begin
            if (ram_cs_o) cs_total <= cs_total + 1;
            if (ram_cs_o && ram_we_o) begin
                for (int b = 0; b < SELW; b++)
                    if (ram_sel_o[b]) mem[ram_adr_o][8*b +: 8] <= ram_dat_o[8*b +: 8];
                wr_total <= wr_total + 1;
            end else if (ram_cs_o) begin
                q1 <= mem[ram_adr_o];
            end
            q2 <= q1;
        end
    end
    assign ram_dat_i = q2;

    always @(posedge clk) begin
        if (cpu_ack_o) ack_total <= ack_total + 1;
        if (done_o)    done_total <= done_total + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void ref_write(input int a, input logic [7:0] sel, input logic [63:0] d);
        for (int b = 0; b < SELW; b++)
            if (sel[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
    endfunction

    function automatic void ref_fill(input int dst, input int len, input logic [63:0] pat);
        for (int i = 0; i < len; i++) ref_mem[(dst + i) % N] = pat;
    endfunction

    function automatic void ref_copy(input int src, input int dst, input int len);
        for (int i = 0; i < len; i++) ref_mem[(dst + i) % N] = ref_mem[(src + i) % N];
    endfunction

    function automatic int mem_diff();
        int n = 0;
        for (int i = 0; i < N; i++) if (mem[i] !== ref_mem[i]) n++;
        return n;
    endfunction

    task automatic cpu_access(input logic we, input int adr, input logic [7:0] sel,
                              input logic [63:0] dat, output logic [63:0] rd, output int lat);
        cpu_cs  = 1'b1;
        cpu_we  = we;
        cpu_adr = adr[AW-1:0];
        cpu_sel = sel;
        cpu_dat = dat;
        lat     = 0;
        while (lat < 20) begin
            step();
            lat++;
            if (cpu_ack_o) break;
        end
        rd = cpu_dat_o;
        step();
        cpu_cs = 1'b0;
        cpu_we = 1'b0;
    endtask

    task automatic do_cmd(input logic op, input int src, input int dst, input int len,
                          input logic [63:0] pat, input int budget, output int dk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_src   = src[AW-1:0];
        cmd_dst   = dst[AW-1:0];
        cmd_len   = len[AW:0];
        cmd_fill  = pat;
        step();
        cmd_valid = 1'b0;
        check("cmd_busy_on", 64'(busy_o), 64'd1);
        check("cmd_ready_off", 64'(cmd_ready_o), 64'd0);
        dk = -1;
        for (int k = 1; k <= budget; k++) begin
            if (done_o) begin
                dk = k;
                break;
            end
            step();
        end
        step();
        check("cmd_busy_off", 64'(busy_o), 64'd0);
        check("cmd_ready_on", 64'(cmd_ready_o), 64'd1);
    endtask

    initial begin
        int lat, dk, a, s, d, len, d0, fill_dk, fd;
        logic [63:0] rd, d64, exp, old;
        logic [7:0] sel;
        logic we, op;

        rstn = 1'b0; cpu_cs = 1'b0; cpu_we = 1'b0; cpu_sel = '0; cpu_adr = '0; cpu_dat = '0;
        cmd_valid = 1'b0; cmd_op = 1'b0; cmd_src = '0; cmd_dst = '0; cmd_len = '0; cmd_fill = '0;
        salt = $urandom;
        load_req = 1'b1;
        for (int i = 0; i < N; i++) ref_mem[i] = seed_fn(i);
        step();
        load_req = 1'b0;
        step();
        step();
        check("rst_ready", 64'(cmd_ready_o), 64'd1);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_ram_cs", 64'(ram_cs_o), 64'd0);
        check("rst_ack", 64'(cpu_ack_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        rstn = 1'b1;
        step();

        // directed byte-masked write then read-back
        old = seed_fn(16);
        cpu_access(1'b1, 16, 8'h0F, 64'h1122334455667788, rd, lat);
        check("wr_lat", 64'(lat), 64'd1);
        ref_write(16, 8'h0F, 64'h1122334455667788);
        cpu_access(1'b0, 16, 8'h00, 64'd0, rd, lat);
        check("rd_lat", 64'(lat), 64'd4);
        check("rd_bytes", rd, {old[63:32], 32'h55667788});

        for (int i = 0; i < 16; i++) begin
            a   = $urandom_range(0, 31);
            we  = 1'($urandom_range(0, 1));
            sel = 8'($urandom);
            d64 = {$urandom, $urandom};
            if (we) begin
                cpu_access(1'b1, a, sel, d64, rd, lat);
                check("rnd_wr_lat", 64'(lat), 64'd1);
                ref_write(a, sel, d64);
            end else begin
                exp = ref_mem[a];
                cpu_access(1'b0, a, 8'h00, 64'd0, rd, lat);
                check("rnd_rd_lat", 64'(lat), 64'd4);
                check("rnd_rd_data", rd, exp);
            end
        end

        do_cmd(1'b0, 0, 'h3FFE, 4, 64'h0720, 50, dk);
        check("fill_wrap_done", 64'(dk), 64'd5);
        ref_fill('h3FFE, 4, 64'h0720);
        check("fill_wrap_mem", 64'(mem_diff()), 64'd0);

        do_cmd(1'b1, 80, 0, 160, 64'd0, 1000, dk);
        check("scroll_done", 64'(dk), 64'd641);
        ref_copy(80, 0, 160);
        check("scroll_mem", 64'(mem_diff()), 64'd0);

        for (int i = 0; i < 6; i++) begin
            op  = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 24);
            s   = $urandom_range(0, N - 1);
            d   = (i % 2 == 1) ? (s + N - 4 + $urandom_range(0, 8)) % N : $urandom_range(0, N - 1);
            d64 = {$urandom, $urandom};
            do_cmd(op, s, d, len, d64, 200, dk);
            check("rnd_cmd_done", 64'(dk), op ? 64'(4 * len + 1) : 64'(len + 1));
            if (op) ref_copy(s, d, len);
            else    ref_fill(d, len, d64);
            check("rnd_cmd_mem", 64'(mem_diff()), 64'd0);
        end

        // continuous CPU reads preempting a FILL of 100 cells
        fd  = $urandom_range(0, N - 1);
        d64 = {$urandom, $urandom};
        fill_dk = -1;
        fork
            begin
                do_cmd(1'b0, 0, fd, 100, d64, 1000, fill_dk);
            end
            begin
                int ra, rl;
                logic [63:0] rv, re;
                step();
                for (int r = 0; r < 40; r++) begin
                    ra = (fd + 100 + $urandom_range(0, 2000)) % N;
                    re = ref_mem[ra];
                    cpu_access(1'b0, ra, 8'h00, 64'd0, rv, rl);
                    check("pre_rd_lat", 64'(rl), 64'd4);
                    check("pre_rd_data", rv, re);
                end
            end
        join
        check("pre_fill_done", 64'(fill_dk > 0), 64'd1);
        ref_fill(fd, 100, d64);
        check("pre_fill_mem", 64'(mem_diff()), 64'd0);

        // cs and cmd_valid together in IDLE: CPU first, command next IDLE cycle
        d0 = ack_total;
        a   = $urandom_range(0, N - 1);
        fd  = (a + 10) % N;
        d64 = {$urandom, $urandom};
        cpu_cs = 1'b1; cpu_we = 1'b1; cpu_adr = a[AW-1:0]; cpu_sel = 8'hFF; cpu_dat = d64;
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_dst = fd[AW-1:0]; cmd_len = 15'd3; cmd_fill = ~d64;
        step();
        check("sim_ack", 64'(cpu_ack_o), 64'd1);
        check("sim_busy_c1", 64'(busy_o), 64'd0);
        step();
        cpu_cs = 1'b0; cpu_we = 1'b0;
        check("sim_busy_c2", 64'(busy_o), 64'd0);
        step();
        cmd_valid = 1'b0;
        check("sim_busy_c3", 64'(busy_o), 64'd1);
        len = 3;
        while (!done_o && len < 20) begin
            step();
            len++;
        end
        check("sim_done", 64'(len), 64'd6);
        step();
        step();
        check("sim_ack_once", 64'(ack_total - d0), 64'd1);
        ref_write(a, 8'hFF, d64);
        ref_fill(fd, 3, ~d64);
        check("sim_mem", 64'(mem_diff()), 64'd0);

        d0 = cs_total;
        do_cmd(1'b0, 0, 123, 0, 64'd0, 20, dk);
        check("len0_done", 64'(dk), 64'd1);
        check("len0_no_cs", 64'(cs_total - d0), 64'd0);

        d0  = wr_total;
        d64 = {$urandom, $urandom};
        do_cmd(1'b0, 0, $urandom_range(0, N - 1), N, d64, N + 100, dk);
        check("full_done", 64'(dk), 64'(N + 1));
        check("full_writes", 64'(wr_total - d0), 64'(N));
        ref_fill(0, N, d64);
        check("full_mem", 64'(mem_diff()), 64'd0);

        // asynchronous reset during CP_W1 of a COPY
        d0 = done_total;
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_src = 14'd100; cmd_dst = 14'd200; cmd_len = 15'd5;
        step();
        cmd_valid = 1'b0;
        check("rm_cp_rd_cs", 64'(ram_cs_o), 64'd1);
        check("rm_cp_rd_adr", 64'(ram_adr_o), 64'd100);
        step();
        rstn = 1'b0;
        #1;
        check("rm_busy", 64'(busy_o), 64'd0);
        check("rm_ready", 64'(cmd_ready_o), 64'd1);
        check("rm_adr", 64'(ram_adr_o), 64'd0);
        check("rm_sel", 64'(ram_sel_o), 64'd0);
        check("rm_cpu_dat", cpu_dat_o, 64'd0);
        check("rm_ram_dat", ram_dat_o, 64'd0);
        step();
        step();
        rstn = 1'b1;
        for (int i = 0; i < 30; i++) step();
        check("rm_no_done", 64'(done_total - d0), 64'd0);
        check("rm_mem", 64'(mem_diff()), 64'd0);
        check("rm_idle_ready", 64'(cmd_ready_o), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
